// File: rtl/udc_input_ctrl.sv
// udc_input_ctrl: generates the slow count clock and a debounced, slow-clock-safe direction level x.
// Build macro UDC_HOLD_EN: a synchronized btn_hold freezes the slow clock divider.
module udc_input_ctrl #(
  parameter int DB_CYCLES = 4,
  parameter int DIV       = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_dir,
  input  logic btn_hold,
  output logic slow_clk,
  output logic x,
  output logic dir_changed,
  output logic db_level
);

  localparam int DBW  = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int DIVW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DBW-1:0]  DB_LAST  = DBW'(DB_CYCLES - 1);
  localparam logic [DBW-1:0]  DB_ONE   = DBW'(1);
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(DIV - 1);
  localparam logic [DIVW-1:0] DIV_ONE  = DIVW'(1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_HI,
    PRESSED,
    WAIT_LO
  } db_state_t;

  db_state_t       state;
  logic [DBW-1:0]  db_cnt;
  logic [DIVW-1:0] div_cnt;
  logic            dir_meta;
  logic            dir_sync;
  logic            dir_pending;
  logic            freeze;
  logic            press_accept;
  logic            slow_toggle;
  logic            apply;

  // Two-flop synchronizer for the asynchronous direction button
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dir_meta <= 1'b0;
      dir_sync <= 1'b0;
    end else begin
      dir_meta <= btn_dir;
      dir_sync <= dir_meta;
    end
  end

`ifdef UDC_HOLD_EN
  logic hold_meta;
  logic hold_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_meta <= 1'b0;
      hold_sync <= 1'b0;
    end else begin
      hold_meta <= btn_hold;
      hold_sync <= hold_meta;
    end
  end

  assign freeze = hold_sync;
`else
  logic unused_hold;
  assign unused_hold = btn_hold;
  assign freeze      = 1'b0;
`endif

  assign press_accept = (state == WAIT_HI) && dir_sync && (db_cnt == DB_LAST);
  assign slow_toggle  = !freeze && (div_cnt == DIV_LAST);
  // x may only move while slow_clk is low and stays low through the next edge
  assign apply        = dir_pending && !slow_clk && !slow_toggle;

  // Debounce FSM: a level is accepted only after DB_CYCLES steady samples
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      db_cnt   <= '0;
      db_level <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (dir_sync) begin
            state  <= WAIT_HI;
            db_cnt <= '0;
          end
        end
        WAIT_HI: begin
          if (!dir_sync) begin
            state <= IDLE;
          end else if (db_cnt == DB_LAST) begin
            state    <= PRESSED;
            db_level <= 1'b1;
          end else begin
            db_cnt <= db_cnt + DB_ONE;
          end
        end
        PRESSED: begin
          if (!dir_sync) begin
            state  <= WAIT_LO;
            db_cnt <= '0;
          end
        end
        WAIT_LO: begin
          if (dir_sync) begin
            state <= PRESSED;
          end else if (db_cnt == DB_LAST) begin
            state    <= IDLE;
            db_level <= 1'b0;
          end else begin
            db_cnt <= db_cnt + DB_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Slow clock divider; a held divider keeps both its count and phase
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt  <= '0;
      slow_clk <= 1'b0;
    end else if (!freeze) begin
      if (div_cnt == DIV_LAST) begin
        div_cnt  <= '0;
        slow_clk <= ~slow_clk;
      end else begin
        div_cnt <= div_cnt + DIV_ONE;
      end
    end
  end

  // An apply consumes the pending toggle; a press in the same cycle re-arms it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x           <= 1'b1;
      dir_pending <= 1'b0;
      dir_changed <= 1'b0;
    end else begin
      dir_changed <= apply;
      if (apply) begin
        x           <= ~x;
        dir_pending <= press_accept;
      end else if (press_accept) begin
        dir_pending <= ~dir_pending;
      end
    end
  end

endmodule

// File: tb/tb_udc_input_ctrl.sv
// tb_udc_input_ctrl: directed bench for udc_input_ctrl with hand-computed cycle expectations.
// A second instance with DIV=16 gives a slow_clk high phase long enough for two accepted presses.
module tb_udc_input_ctrl;

  logic clk;
  logic reset;
  logic btn_dir;
  logic btn_hold;
  logic slow_clk;
  logic x;
  logic dir_changed;
  logic db_level;

  logic btn_dir16;
  logic slow_clk16;
  logic x16;
  logic dir_changed16;
  logic db_level16;

  int checks;
  int errors;
  int cyc;
  int pulses;
  int pulses16;
  int dbHigh;

  udc_input_ctrl #(.DB_CYCLES(4), .DIV(4)) dut (
    .clk(clk),
    .reset(reset),
    .btn_dir(btn_dir),
    .btn_hold(btn_hold),
    .slow_clk(slow_clk),
    .x(x),
    .dir_changed(dir_changed),
    .db_level(db_level)
  );

  udc_input_ctrl #(.DB_CYCLES(4), .DIV(16)) dut16 (
    .clk(clk),
    .reset(reset),
    .btn_dir(btn_dir16),
    .btn_hold(1'b0),
    .slow_clk(slow_clk16),
    .x(x16),
    .dir_changed(dir_changed16),
    .db_level(db_level16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cyc %0d)", tag, actual, expected, cyc);
    end
  endtask

  // One clock: sample 1 ns after the rising edge and accumulate pulse/level counts
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    cyc++;
    if (dir_changed) pulses++;
    if (dir_changed16) pulses16++;
    if (db_level) dbHigh++;
  endtask

  task automatic runTicks(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  task automatic alignTo(input int period, input int phase);
    while ((cyc % period) != phase) applyStimulus();
  endtask

  initial begin
    int c;
    int p0;
    int d0;
    int slowHigh;
    checks   = 0;
    errors   = 0;
    cyc      = 0;
    pulses   = 0;
    pulses16 = 0;
    dbHigh   = 0;
    btn_dir   = 1'b0;
    btn_dir16 = 1'b0;
    btn_hold  = 1'b0;
    reset     = 1'b0;

    // Test 1: reset values, then free-running slow clock
    #1 reset = 1'b1;
    #19;
    checkOutput("rst_slow_clk", slow_clk, 0);
    checkOutput("rst_x", x, 1);
    checkOutput("rst_dir_changed", dir_changed, 0);
    checkOutput("rst_db_level", db_level, 0);
    #30 reset = 1'b0;
    cyc = 0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus();
      checkOutput("slow_clk_wave", slow_clk, ((cyc % 8) >= 4) ? 1 : 0);
    end
    checkOutput("x_after_reset", x, 1);

    // Test 2: short bounces never get accepted
    p0 = pulses;
    d0 = dbHigh;
    btn_dir = 1'b1; runTicks(2);
    btn_dir = 1'b0; runTicks(2);
    btn_dir = 1'b1; runTicks(2);
    btn_dir = 1'b0; runTicks(12);
    checkOutput("bounce_db_level", dbHigh - d0, 0);
    checkOutput("bounce_x", x, 1);
    checkOutput("bounce_pulses", pulses - p0, 0);

    // Test 3: full press, pending becomes set while slow_clk is high
    alignTo(8, 5);
    c  = cyc;
    p0 = pulses;
    btn_dir = 1'b1;
    runTicks(6);
    checkOutput("press_db_early", db_level, 0);
    applyStimulus();
    checkOutput("press_db_level", db_level, 1);
    checkOutput("press_x_held", x, 1);
    runTicks(3);
    btn_dir = 1'b0;
    applyStimulus();
    checkOutput("apply_x_before", x, 1);
    checkOutput("apply_pulse_before", dir_changed, 0);
    applyStimulus();
    checkOutput("apply_x", x, 0);
    checkOutput("apply_pulse", dir_changed, 1);
    checkOutput("apply_slow_low", slow_clk, 0);
    applyStimulus();
    checkOutput("apply_pulse_end", dir_changed, 0);
    runTicks(3);
    checkOutput("release_db_hold", db_level, 1);
    applyStimulus();
    checkOutput("release_db_level", db_level, 0);
    checkOutput("press_pulse_count", pulses - p0, 1);
    checkOutput("press_cycle_offset", cyc - c, 17);

    // Test 4: two accepted presses inside one slow_clk high phase cancel out
    alignTo(32, 9);
    p0 = pulses16;
    btn_dir16 = 1'b1;
    runTicks(5);
    btn_dir16 = 1'b0;
    runTicks(2);
    checkOutput("dbl_db_first", db_level16, 1);
    checkOutput("dbl_slow_high", slow_clk16, 1);
    runTicks(3);
    btn_dir16 = 1'b1;
    runTicks(2);
    checkOutput("dbl_db_released", db_level16, 0);
    runTicks(5);
    checkOutput("dbl_db_second", db_level16, 1);
    runTicks(40);
    btn_dir16 = 1'b0;
    checkOutput("dbl_x16", x16, 1);
    checkOutput("dbl_pulses16", pulses16 - p0, 0);

`ifdef UDC_HOLD_EN
    // Test 5: hold freezes the divider with slow_clk low and div_cnt at 2
    alignTo(8, 0);
    c = cyc;
    btn_hold = 1'b1;
    runTicks(2);
    slowHigh = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus();
      if (slow_clk) slowHigh++;
      if (cyc == c + 20) btn_hold = 1'b0;
    end
    checkOutput("hold_slow_frozen", slowHigh, 0);
    applyStimulus();
    checkOutput("hold_resume_low", slow_clk, 0);
    applyStimulus();
    checkOutput("hold_resume_toggle", slow_clk, 1);
`endif

    // Test 6: reset in the middle of WAIT_HI discards the partial press
    runTicks(3);
    btn_dir = 1'b1;
    runTicks(5);
    reset = 1'b1;
    #1;
    checkOutput("midrst_db_level", db_level, 0);
    checkOutput("midrst_x", x, 1);
    checkOutput("midrst_slow_clk", slow_clk, 0);
    checkOutput("midrst_dir_changed", dir_changed, 0);
    btn_dir = 1'b0;
    runTicks(2);
    reset = 1'b0;
    cyc = 0;
    p0 = pulses;
    d0 = dbHigh;
    runTicks(30);
    checkOutput("postrst_pulses", pulses - p0, 0);
    checkOutput("postrst_x", x, 1);
    checkOutput("postrst_db_level", dbHigh - d0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
